canny_threshold_linebuf: RTL and testbench

//   Upstream neighbour of the Canny hysteresis stage. Classifies each NMS magnitude pixel as

---
 rtl/canny_threshold_linebuf_if.sv | 48 ++++
 rtl/canny_threshold_linebuf.sv | 135 +++++++++++++
 tb/tb_canny_threshold_linebuf.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/canny_threshold_linebuf_if.sv
// Pixel stream bundle for canny_threshold_linebuf.
// With THRESH_PORTS_EN defined it also carries the high_th/low_th threshold inputs.
interface canny_threshold_linebuf_if #(
  parameter int WIDTH = 8
);
  logic             frame_start;
  logic             valid_in;
  logic [WIDTH-1:0] din;
`ifdef THRESH_PORTS_EN
  logic [WIDTH-1:0] high_th;
  logic [WIDTH-1:0] low_th;
`endif
  logic             valid_out;
  logic [WIDTH-1:0] dout1;
  logic [WIDTH-1:0] dout2;
  logic [WIDTH-1:0] dout3;
  logic             rows_ok;

  modport master (
`ifdef THRESH_PORTS_EN
    output high_th,
    output low_th,
`endif
    output frame_start,
    output valid_in,
    output din,
    input  valid_out,
    input  dout1,
    input  dout2,
    input  dout3,
    input  rows_ok
  );

  modport slave (
`ifdef THRESH_PORTS_EN
    input  high_th,
    input  low_th,
`endif
    input  frame_start,
    input  valid_in,
    input  din,
    output valid_out,
    output dout1,
    output dout2,
    output dout3,
    output rows_ok
  );
endinterface

// File: rtl/canny_threshold_linebuf.sv
// Double-threshold classifier plus two-line buffer producing a column-aligned 3-row tap.
// Optional THRESH_PORTS_EN: thresholds come from ports, captured on frame_start.
module canny_threshold_linebuf #(
  parameter logic [10:0]      PIC_WIDTH = 11'd250,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] HIGH_TH   = 8'd100,
  parameter logic [WIDTH-1:0] LOW_TH    = 8'd40,
  parameter logic [WIDTH-1:0] WEAK_VAL  = 8'd128
) (
  input logic                        clk,
  input logic                        rst,
  canny_threshold_linebuf_if.slave   bus
);
  localparam int AW = $clog2(int'(PIC_WIDTH));

  logic [WIDTH-1:0] hi_s;
  logic [WIDTH-1:0] lo_s;
  logic [WIDTH-1:0] cls_q;
  logic             v1_q;
  logic [10:0]      col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [AW-1:0]    col_idx_s;
  logic             valid_q;
  logic [WIDTH-1:0] dout1_q, dout2_q, dout3_q;
  logic             rows_ok_q;
  logic [WIDTH-1:0] lb0_q [PIC_WIDTH];
  logic [WIDTH-1:0] lb1_q [PIC_WIDTH];

  // High comparison wins, so LOW_TH > HIGH_TH simply yields no weak codes.
  function automatic logic [WIDTH-1:0] classify(input logic [WIDTH-1:0] d,
                                                input logic [WIDTH-1:0] hi,
                                                input logic [WIDTH-1:0] lo);
    if (d >= hi) begin
      return {WIDTH{1'b1}};
    end else if (d >= lo) begin
      return WEAK_VAL;
    end else begin
      return {WIDTH{1'b0}};
    end
  endfunction

`ifdef THRESH_PORTS_EN
  logic [WIDTH-1:0] high_q;
  logic [WIDTH-1:0] low_q;

  // Thresholds are frozen for the whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_q <= HIGH_TH;
      low_q  <= LOW_TH;
    end else if (bus.frame_start) begin
      high_q <= bus.high_th;
      low_q  <= bus.low_th;
    end
  end

  assign hi_s = high_q;
  assign lo_s = low_q;
`else
  assign hi_s = HIGH_TH;
  assign lo_s = LOW_TH;
`endif

  assign col_idx_s = col_q[AW-1:0];

  // Column advances only on valid stage-1 data; any idle cycle restarts the line at 0.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (v1_q) begin
      if (col_q == PIC_WIDTH - 11'd1) begin
        col_d = 11'd0;
      end else begin
        col_d = col_q + 11'd1;
      end
    end else begin
      col_d = 11'd0;
    end
    if (bus.frame_start) begin
      row_d = 2'd0;
    end else if (v1_q && (col_q == PIC_WIDTH - 11'd1) && (row_q != 2'd2)) begin
      row_d = row_q + 2'd1;
    end else begin
      row_d = row_q;
    end
  end

  // Stage 1 classification and position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_q <= {WIDTH{1'b0}};
      v1_q  <= 1'b0;
      col_q <= 11'd0;
      row_q <= 2'd0;
    end else begin
      cls_q <= classify(bus.din, hi_s, lo_s);
      v1_q  <= bus.valid_in;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Stage 2 output tap; rows not yet buffered in this frame read as 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      dout1_q   <= {WIDTH{1'b0}};
      dout2_q   <= {WIDTH{1'b0}};
      dout3_q   <= {WIDTH{1'b0}};
      rows_ok_q <= 1'b0;
    end else begin
      valid_q <= v1_q;
      if (v1_q) begin
        dout3_q   <= cls_q;
        dout2_q   <= (row_q != 2'd0) ? lb0_q[col_idx_s] : {WIDTH{1'b0}};
        dout1_q   <= (row_q == 2'd2) ? lb1_q[col_idx_s] : {WIDTH{1'b0}};
        rows_ok_q <= (row_q == 2'd2);
      end
    end
  end

  // Line buffers shift down one row per column, read-before-write in the same cycle.
  always_ff @(posedge clk) begin
    if (v1_q) begin
      lb0_q[col_idx_s] <= cls_q;
      lb1_q[col_idx_s] <= lb0_q[col_idx_s];
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.dout1     = dout1_q;
  assign bus.dout2     = dout2_q;
  assign bus.dout3     = dout3_q;
  assign bus.rows_ok   = rows_ok_q;
endmodule

// File: tb/tb_canny_threshold_linebuf.sv
// Directed bench for canny_threshold_linebuf with PIC_WIDTH=4; expectations queued per pixel.
module tb_canny_threshold_linebuf;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  typedef struct {
    logic [7:0] e1;
    logic [7:0] e2;
    logic [7:0] e3;
    logic       ok;
    int         c;
  } exp_t;
  exp_t q[$];

  canny_threshold_linebuf_if #(.WIDTH(8)) bus ();

  canny_threshold_linebuf #(
    .PIC_WIDTH(11'd4), .WIDTH(8), .HIGH_TH(8'd100), .LOW_TH(8'd40), .WEAK_VAL(8'd128)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.valid_out === 1'b1) begin
      if (q.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("latency", cyc - e.c, 32'd2);
        check("dout1", {24'd0, bus.dout1}, {24'd0, e.e1});
        check("dout2", {24'd0, bus.dout2}, {24'd0, e.e2});
        check("dout3", {24'd0, bus.dout3}, {24'd0, e.e3});
        check("rows_ok", {31'd0, bus.rows_ok}, {31'd0, e.ok});
      end
    end
  endtask

  task automatic pix(input logic [7:0] d, input logic [7:0] e1, input logic [7:0] e2,
                     input logic [7:0] e3, input logic ok);
    exp_t e;
    bus.valid_in = 1'b1;
    bus.din      = d;
    e.e1 = e1; e.e2 = e2; e.e3 = e3; e.ok = ok; e.c = cyc;
    q.push_back(e);
    tick();
  endtask

  task automatic gap(input int n);
    bus.valid_in = 1'b0;
    bus.din      = 8'd0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic fstart();
    bus.valid_in    = 1'b0;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, {31'd0, bus.valid_out}, 32'd0);
    check({tag, "_d1"}, {24'd0, bus.dout1}, 32'd0);
    check({tag, "_d2"}, {24'd0, bus.dout2}, 32'd0);
    check({tag, "_d3"}, {24'd0, bus.dout3}, 32'd0);
    check({tag, "_rows_ok"}, {31'd0, bus.rows_ok}, 32'd0);
  endtask

  initial begin
    logic [7:0] lv [3];
    logic [7:0] lc [3];
    logic [7:0] e1g [4];
    logic [7:0] e2g [4];
    logic [7:0] r1  [4];
    logic [7:0] r2  [4];
    bus.frame_start = 1'b0;
    bus.valid_in    = 1'b0;
    bus.din         = 8'd0;
`ifdef THRESH_PORTS_EN
    bus.high_th = 8'd100;
    bus.low_th  = 8'd40;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    tick();

    // 1: classification boundaries; second line (cols 0,1) sees row 1 of zeros
    pix(8'd0,   8'd0, 8'd0, 8'd0,   1'b0);
    pix(8'd39,  8'd0, 8'd0, 8'd0,   1'b0);
    pix(8'd40,  8'd0, 8'd0, 8'd128, 1'b0);
    pix(8'd99,  8'd0, 8'd0, 8'd128, 1'b0);
    pix(8'd100, 8'd0, 8'd0, 8'd255, 1'b0);
    pix(8'd255, 8'd0, 8'd0, 8'd255, 1'b0);
    gap(3);

    // 2: three lines 100/50/0 after frame_start
    fstart();
    lv[0] = 8'd100; lv[1] = 8'd50;  lv[2] = 8'd0;
    lc[0] = 8'd255; lc[1] = 8'd128; lc[2] = 8'd0;
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < 4; c++) begin
        pix(lv[l], (l >= 2) ? lc[0] : 8'd0, (l >= 1) ? lc[l-1] : 8'd0, lc[l], (l >= 2));
      end
    end

    // 3: short line of 3, 2-cycle gap, then full line; lb0=[128,128,128,0], lb1=[0,0,0,128]
    pix(8'd40, 8'd128, 8'd0, 8'd128, 1'b1);
    pix(8'd40, 8'd128, 8'd0, 8'd128, 1'b1);
    pix(8'd40, 8'd128, 8'd0, 8'd128, 1'b1);
    gap(2);
    check("hold_dout3", {24'd0, bus.dout3}, 32'd128);
    e1g[0] = 8'd0;   e1g[1] = 8'd0;   e1g[2] = 8'd0;   e1g[3] = 8'd128;
    e2g[0] = 8'd128; e2g[1] = 8'd128; e2g[2] = 8'd128; e2g[3] = 8'd0;
    for (int c = 0; c < 4; c++) pix(8'd100, e1g[c], e2g[c], 8'd255, 1'b1);
    gap(2);

    // 4: frame restart hides previous rows
    fstart();
    for (int c = 0; c < 4; c++) pix(8'd40, 8'd0, 8'd0, 8'd128, 1'b0);
    gap(2);

    // 5: reset mid-line (row 1, lb0 all 128)
    pix(8'd100, 8'd0, 8'd128, 8'd255, 1'b0);
    pix(8'd100, 8'd0, 8'd128, 8'd255, 1'b0);
    bus.din = 8'd100;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    q.delete();
    bus.valid_in = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    r1[0] = 8'd100; r1[1] = 8'd50;  r1[2] = 8'd0; r1[3] = 8'd50;
    r2[0] = 8'd255; r2[1] = 8'd128; r2[2] = 8'd0; r2[3] = 8'd128;
    for (int c = 0; c < 4; c++) pix(r1[c], 8'd0, 8'd0, r2[c], 1'b0);
    for (int c = 0; c < 4; c++) pix(8'd0, 8'd0, r2[c], 8'd0, 1'b0);
    gap(2);

`ifdef THRESH_PORTS_EN
    // 6: thresholds latched at frame_start only
    bus.high_th = 8'd200;
    bus.low_th  = 8'd10;
    fstart();
    bus.high_th = 8'd50;
    bus.low_th  = 8'd50;
    pix(8'd150, 8'd0, 8'd0, 8'd128, 1'b0);
    pix(8'd5,   8'd0, 8'd0, 8'd0,   1'b0);
    pix(8'd10,  8'd0, 8'd0, 8'd128, 1'b0);
    pix(8'd200, 8'd0, 8'd0, 8'd255, 1'b0);
    gap(2);
    fstart();
    pix(8'd150, 8'd0, 8'd0, 8'd255, 1'b0);
    pix(8'd5,   8'd0, 8'd0, 8'd0,   1'b0);
    pix(8'd49,  8'd0, 8'd0, 8'd0,   1'b0);
    pix(8'd50,  8'd0, 8'd0, 8'd255, 1'b0);
    gap(2);
`endif

    gap(3);
    check("drain", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
